// File: rtl/jedro_1_dram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_defines
// Shared definitions for the jedro_1 data-memory arbiter.
//   arb_state_e              : arbiter FSM states (IDLE, BUSY)
//   DRAM_ARB_TIMEOUT_DEFAULT : default slave-ack timeout in cycles, used when
//                              JEDRO_1_DRAM_ARB_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package jedro_1_defines;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DRAM_ARB_TIMEOUT_DEFAULT = 16;

endpackage : jedro_1_defines

// File: rtl/jedro_1_dram_arbiter_wdt.sv
// -----------------------------------------------------------------------------
// jedro_1_arb_wdt
// 8-bit cycle counter used as a slave-response watchdog. Only instantiated
// by jedro_1_dram_arbiter when JEDRO_1_DRAM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset, count -> 0
//   clr    : synchronous clear (takes priority over en)
//   en     : count enable; counting stops once the terminal count is reached
//   tc     : terminal count, high while count == LIMIT
// -----------------------------------------------------------------------------
module jedro_1_arb_wdt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LIMIT_CNT = 8'(LIMIT);

    logic [7:0] count_q;

    assign tc = (count_q == LIMIT_CNT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule : jedro_1_arb_wdt

// File: rtl/jedro_1_dram_arbiter.sv
// -----------------------------------------------------------------------------
// jedro_1_dram_arbiter
// Two-master / one-slave arbiter for the jedro_1 data-memory port
// (stb/we/addr/wdata/rdata/ack/err). Master 0 is the core LSU, master 1 a
// secondary requester (debug/DMA). One transaction at a time, round-robin on
// contention, response routed combinationally back to the granted master.
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   mX_stb/we/addr/wdata   : master X request (held until ack or err)
//   mX_rdata/ack/err       : master X response (zero when not granted)
//   s_stb/we/addr/wdata    : registered slave command
//   s_rdata/ack/err        : slave response
// Optional feature macro: JEDRO_1_DRAM_ARB_TIMEOUT_EN
//   Adds a BUSY watchdog (jedro_1_arb_wdt); after TIMEOUT_CYCLES cycles
//   without s_ack/s_err the granted master receives an err pulse.
// -----------------------------------------------------------------------------
module jedro_1_dram_arbiter
    import jedro_1_defines::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DRAM_ARB_TIMEOUT_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    m0_stb,
    input  logic [DATA_WIDTH/8-1:0] m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic                    m1_stb,
    input  logic [DATA_WIDTH/8-1:0] m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic                    s_stb,
    output logic [DATA_WIDTH/8-1:0] s_we,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_ack,
    input  logic                    s_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    arb_state_e              state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_q, last_d;
    logic                    s_stb_d;
    logic [BE_WIDTH-1:0]     s_we_d;
    logic [ADDR_WIDTH-1:0]   s_addr_d;
    logic [DATA_WIDTH-1:0]   s_wdata_d;

    logic busy;
    logic timeout;
    logic winner;
    logic done;
    logic err_fwd;

    assign busy = (state_q == BUSY);

`ifdef JEDRO_1_DRAM_ARB_TIMEOUT_EN
    // Held clear while idle, so the count is 0 on the first BUSY cycle.
    jedro_1_arb_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr    (!busy),
        .en     (busy),
        .tc     (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // On contention the master that was not served last wins; otherwise the
    // only requester wins (m1_stb alone selects 1, anything else selects 0).
    assign winner = (m0_stb && m1_stb) ? ~last_q : m1_stb;

    assign done    = busy && (s_ack || s_err || timeout);
    // A real slave response takes precedence over a coincident timeout.
    assign err_fwd = s_err || (timeout && !s_ack);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            s_stb   <= 1'b0;
            s_we    <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            s_stb   <= s_stb_d;
            s_we    <= s_we_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        s_stb_d   = s_stb;
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;

        case (state_q)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    state_d   = BUSY;
                    grant_d   = winner;
                    last_d    = winner;
                    s_stb_d   = 1'b1;
                    s_we_d    = winner ? m1_we    : m0_we;
                    s_addr_d  = winner ? m1_addr  : m0_addr;
                    s_wdata_d = winner ? m1_wdata : m0_wdata;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    s_stb_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                s_stb_d = 1'b0;
            end
        endcase
    end

    // Response routing is gated on BUSY so a reset (state -> IDLE) silences
    // every master output immediately, and stray slave responses in IDLE
    // never reach a master.
    always_comb begin
        m0_ack   = busy && !grant_q && s_ack;
        m1_ack   = busy &&  grant_q && s_ack;
        m0_err   = busy && !grant_q && err_fwd;
        m1_err   = busy &&  grant_q && err_fwd;
        m0_rdata = (busy && !grant_q) ? s_rdata : '0;
        m1_rdata = (busy &&  grant_q) ? s_rdata : '0;
    end

endmodule : jedro_1_dram_arbiter
